// File: rtl/vproc_sld_seq.sv
// Slide-unit sequencer: expands one slide-up/slide-down command into a stream of
// per-part beats, fetching each source part through a single register-file read port.
module vproc_sld_seq #(
  parameter  int unsigned VREG_W   = 128,
  parameter  int unsigned SLD_OP_W = 64,
  localparam int unsigned BPP      = SLD_OP_W / 8,
  localparam int unsigned P        = VREG_W / SLD_OP_W,
  localparam int unsigned PW       = $clog2(P),
  localparam int unsigned SW       = $clog2(BPP),
  localparam int unsigned VLW      = $clog2(VREG_W / 8) + 1
) (
  input  logic                clk_i,
  input  logic                async_rst_i,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic                cmd_dir_i,
  input  logic [15:0]         cmd_amt_i,
  input  logic [VLW-1:0]      cmd_vl_i,
  output logic                rd_o,
  output logic [PW-1:0]       rd_part_o,
  input  logic [SLD_OP_W-1:0] rd_data_i,
  output logic                sld_valid_o,
  input  logic                sld_ready_i,
  output logic [SLD_OP_W-1:0] sld_op_o,
  output logic                sld_op_valid_o,
  output logic                sld_first_o,
  output logic                sld_last_o,
  output logic                sld_wr_o,
  output logic [PW-1:0]       sld_dst_o,
  output logic [SW-1:0]       sld_shift_o,
  output logic [SW-1:0]       sld_vl_part_o,
  output logic                done_o
);

  localparam int unsigned NBW = PW + 2;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] ISSUE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;
  localparam logic [16:0] P17  = 17'(P);

  logic [1:0]          state_q;
  logic                dir_q, sx_q, rd_pend_q;
  logic [16:0]         off_q, last_dst_q;
  logic [SW-1:0]       shift_q, vl_last_q;
  logic [NBW-1:0]      nb_q, b_q;

  logic [SLD_OP_W-1:0] op_p1;
  logic                op_vld_p1, first_p1, last_p1, wr_p1;
  logic [PW-1:0]       dst_p1;
  logic [SW-1:0]       vl_part_p1;

  logic [VLW-1:0]      vlm1_in;
  logic [16:0]         off_in, last_dst_in, nb_in17, s0_in;
  logic                sx_in;
  logic [NBW-1:0]      nb_in;
  logic [16:0]         b17, cur_s, cur_d, nxt_s, rd_s;
  logic                beat_last, accept, rd_req;

  // Command decode; offsets kept at 17 bits so a large amount never wraps into range
  always_comb begin
    vlm1_in     = cmd_vl_i - VLW'(1);
    off_in      = 17'(cmd_amt_i >> SW);
    last_dst_in = 17'(vlm1_in >> SW);
    sx_in       = cmd_dir_i & (cmd_amt_i[SW-1:0] != '0);
    if (cmd_dir_i)
      nb_in17 = last_dst_in + 17'd1 + 17'(sx_in);
    else if (off_in <= last_dst_in)
      nb_in17 = last_dst_in - off_in + 17'd1;
    else
      nb_in17 = '0;
    nb_in = NBW'(nb_in17);
    s0_in = cmd_dir_i ? off_in : '0;
  end

  always_comb begin
    b17       = 17'(b_q);
    cur_s     = dir_q ? off_q + b17 : b17;
    cur_d     = dir_q ? b17 - 17'(sx_q) : off_q + b17;
    nxt_s     = cur_s + 17'd1;
    beat_last = (b_q == nb_q - NBW'(1));
    accept    = (state_q == IDLE) && cmd_valid_i;
    rd_req    = (accept && (nb_in != '0) && (s0_in < P17)) ||
                ((state_q == ISSUE) && sld_ready_i && !beat_last && (nxt_s < P17));
    rd_s      = (state_q == IDLE) ? s0_in : nxt_s;
  end

  assign rd_o      = rd_req;
  assign rd_part_o = rd_req ? PW'(rd_s) : '0;

  always_ff @(posedge clk_i or posedge async_rst_i) begin
    if (async_rst_i) begin
      state_q    <= IDLE;
      dir_q      <= 1'b0;
      sx_q       <= 1'b0;
      rd_pend_q  <= 1'b0;
      off_q      <= '0;
      last_dst_q <= '0;
      shift_q    <= '0;
      vl_last_q  <= '0;
      nb_q       <= '0;
      b_q        <= '0;
      op_p1      <= '0;
      op_vld_p1  <= 1'b0;
      first_p1   <= 1'b0;
      last_p1    <= 1'b0;
      wr_p1      <= 1'b0;
      dst_p1     <= '0;
      vl_part_p1 <= '0;
    end else begin
      case (state_q)
        IDLE: if (cmd_valid_i) begin
          dir_q      <= cmd_dir_i;
          sx_q       <= sx_in;
          off_q      <= off_in;
          last_dst_q <= last_dst_in;
          shift_q    <= cmd_amt_i[SW-1:0];
          vl_last_q  <= vlm1_in[SW-1:0];
          nb_q       <= nb_in;
          b_q        <= '0;
          rd_pend_q  <= rd_req;
          state_q    <= (nb_in == '0) ? DONE : FETCH;
        end
        // Stage p1: capture read data and the beat's flags so ISSUE drives registers only
        FETCH: begin
          op_p1      <= rd_pend_q ? rd_data_i : '0;
          op_vld_p1  <= (cur_s < P17);
          first_p1   <= (b_q == '0);
          last_p1    <= beat_last;
          wr_p1      <= !(sx_q && (b_q == '0));
          dst_p1     <= cur_d[PW-1:0];
          vl_part_p1 <= (cur_d == last_dst_q) ? vl_last_q : '1;
          state_q    <= ISSUE;
        end
        ISSUE: if (sld_ready_i) begin
          if (beat_last) begin
            state_q <= DONE;
          end else begin
            b_q       <= b_q + NBW'(1);
            rd_pend_q <= rd_req;
            state_q   <= FETCH;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready_o    = (state_q == IDLE);
  assign sld_valid_o    = (state_q == ISSUE);
  assign done_o         = (state_q == DONE);
  assign sld_op_o       = op_p1;
  assign sld_op_valid_o = op_vld_p1;
  assign sld_first_o    = first_p1;
  assign sld_last_o     = last_p1;
  assign sld_wr_o       = wr_p1;
  assign sld_dst_o      = dst_p1;
  assign sld_shift_o    = shift_q;
  assign sld_vl_part_o  = vl_part_p1;

endmodule

// File: tb/tb_vproc_sld_seq.sv
// Directed bench for vproc_sld_seq at default widths (VREG_W=128, SLD_OP_W=64, two parts).
module tb_vproc_sld_seq;
  localparam int unsigned PW  = 1;
  localparam int unsigned SW  = 3;
  localparam int unsigned VLW = 5;
  localparam logic [63:0] D0   = 64'h1111_2222_3333_4444;
  localparam logic [63:0] D1   = 64'h5555_6666_7777_8888;
  localparam logic [63:0] JUNK = 64'hBAD0_BAD0_BAD0_BAD0;

  logic           clk = 1'b0;
  logic           async_rst_i;
  logic           cmd_valid_i, cmd_ready_o, cmd_dir_i;
  logic [15:0]    cmd_amt_i;
  logic [VLW-1:0] cmd_vl_i;
  logic           rd_o;
  logic [PW-1:0]  rd_part_o;
  logic [63:0]    rd_data_i;
  logic           sld_valid_o, sld_ready_i;
  logic [63:0]    sld_op_o;
  logic           sld_op_valid_o, sld_first_o, sld_last_o, sld_wr_o;
  logic [PW-1:0]  sld_dst_o;
  logic [SW-1:0]  sld_shift_o, sld_vl_part_o;
  logic           done_o;

  int total = 0, passed = 0, fails = 0, rd_n = 0;
  logic [PW-1:0] rd_log [8];

  always #5 clk = ~clk;

  vproc_sld_seq dut (
    .clk_i(clk), .async_rst_i(async_rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_dir_i(cmd_dir_i),
    .cmd_amt_i(cmd_amt_i), .cmd_vl_i(cmd_vl_i),
    .rd_o(rd_o), .rd_part_o(rd_part_o), .rd_data_i(rd_data_i),
    .sld_valid_o(sld_valid_o), .sld_ready_i(sld_ready_i), .sld_op_o(sld_op_o),
    .sld_op_valid_o(sld_op_valid_o), .sld_first_o(sld_first_o), .sld_last_o(sld_last_o),
    .sld_wr_o(sld_wr_o), .sld_dst_o(sld_dst_o), .sld_shift_o(sld_shift_o),
    .sld_vl_part_o(sld_vl_part_o), .done_o(done_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; the register file answers a read one cycle after rd_o.
  task automatic tick();
    logic r;
    logic [PW-1:0] p;
    #3;
    r = rd_o;
    p = rd_part_o;
    if (r) begin
      if (rd_n < 8) rd_log[rd_n] = p;
      rd_n++;
    end
    @(posedge clk);
    #1;
    rd_data_i = r ? ((p == 1'b1) ? D1 : D0) : JUNK;
  endtask

  task automatic accept(input logic dir, input logic [15:0] amt, input logic [VLW-1:0] vl);
    rd_n = 0;
    chk("accept.ready", 64'(cmd_ready_o), 64'd1);
    cmd_valid_i = 1'b1;
    cmd_dir_i   = dir;
    cmd_amt_i   = amt;
    cmd_vl_i    = vl;
    tick();
    cmd_valid_i = 1'b0;
  endtask

  task automatic chk_beat(input string tag, input logic [63:0] op, input logic opv,
                          input logic first, input logic last, input logic wr,
                          input logic [PW-1:0] dst, input logic [SW-1:0] sh,
                          input logic [SW-1:0] vp, input logic chk_dst);
    chk({tag, ".valid"}, 64'(sld_valid_o), 64'd1);
    chk({tag, ".op"}, sld_op_o, op);
    chk({tag, ".opv"}, 64'(sld_op_valid_o), 64'(opv));
    chk({tag, ".first"}, 64'(sld_first_o), 64'(first));
    chk({tag, ".last"}, 64'(sld_last_o), 64'(last));
    chk({tag, ".wr"}, 64'(sld_wr_o), 64'(wr));
    chk({tag, ".shift"}, 64'(sld_shift_o), 64'(sh));
    if (chk_dst) begin
      chk({tag, ".dst"}, 64'(sld_dst_o), 64'(dst));
      chk({tag, ".vp"}, 64'(sld_vl_part_o), 64'(vp));
    end
  endtask

  initial begin
    async_rst_i = 1'b1;
    cmd_valid_i = 1'b0; cmd_dir_i = 1'b0; cmd_amt_i = '0; cmd_vl_i = '0;
    sld_ready_i = 1'b1; rd_data_i = JUNK;
    tick(); tick();
    chk("rst.ready", 64'(cmd_ready_o), 64'd1);
    chk("rst.valid", 64'(sld_valid_o), 64'd0);
    chk("rst.rd", 64'(rd_o), 64'd0);
    chk("rst.done", 64'(done_o), 64'd0);
    chk("rst.first", 64'(sld_first_o), 64'd0);
    chk("rst.op", sld_op_o, 64'd0);
    chk("rst.shift", 64'(sld_shift_o), 64'd0);
    chk("rst.vp", 64'(sld_vl_part_o), 64'd0);
    async_rst_i = 1'b0;
    tick();

    // Up, amt=3, vl=16: two beats, reads of parts 0 then 1, done in cycle 5
    accept(1'b0, 16'd3, 5'd16);
    chk("t1.fetch_valid", 64'(sld_valid_o), 64'd0);
    chk("t1.ready_busy", 64'(cmd_ready_o), 64'd0);
    tick();
    chk_beat("t1b0", D0, 1, 1, 0, 1, 1'b0, 3'd3, 3'd7, 1);
    tick(); tick();
    chk_beat("t1b1", D1, 1, 0, 1, 1, 1'b1, 3'd3, 3'd7, 1);
    tick();
    chk("t1.done", 64'(done_o), 64'd1);
    chk("t1.rd_n", 64'(rd_n), 64'd2);
    chk("t1.rd0", 64'(rd_log[0]), 64'd0);
    chk("t1.rd1", 64'(rd_log[1]), 64'd1);
    tick();
    chk("t1.done_clr", 64'(done_o), 64'd0);

    // Down, amt=11, vl=16: leading no-write beat, then two out-of-range sources
    accept(1'b1, 16'd11, 5'd16);
    tick();
    chk_beat("t2b0", D1, 1, 1, 0, 0, 1'b0, 3'd3, 3'd7, 0);
    tick(); tick();
    chk_beat("t2b1", 64'd0, 0, 0, 0, 1, 1'b0, 3'd3, 3'd7, 1);
    tick(); tick();
    chk_beat("t2b2", 64'd0, 0, 0, 1, 1, 1'b1, 3'd3, 3'd7, 1);
    tick();
    chk("t2.done", 64'(done_o), 64'd1);
    chk("t2.rd_n", 64'(rd_n), 64'd1);
    chk("t2.rd0", 64'(rd_log[0]), 64'd1);
    tick();

    // Down, amt=8, vl=12: whole-part slide, partial last destination
    accept(1'b1, 16'd8, 5'd12);
    tick();
    chk_beat("t3b0", D1, 1, 1, 0, 1, 1'b0, 3'd0, 3'd7, 1);
    tick(); tick();
    chk_beat("t3b1", 64'd0, 0, 0, 1, 1, 1'b1, 3'd0, 3'd3, 1);
    tick();
    chk("t3.done", 64'(done_o), 64'd1);
    chk("t3.rd_n", 64'(rd_n), 64'd1);
    tick();

    // Up, amt=16, vl=16: nothing to do
    accept(1'b0, 16'd16, 5'd16);
    chk("t4.rd_n", 64'(rd_n), 64'd0);
    chk("t4.done", 64'(done_o), 64'd1);
    chk("t4.valid", 64'(sld_valid_o), 64'd0);
    tick();
    chk("t4.idle", 64'(cmd_ready_o), 64'd1);

    // Up, amt=0, vl=5: single beat
    accept(1'b0, 16'd0, 5'd5);
    tick();
    chk_beat("t5b0", D0, 1, 1, 1, 1, 1'b0, 3'd0, 3'd4, 1);
    tick();
    chk("t5.done", 64'(done_o), 64'd1);
    chk("t5.rd_n", 64'(rd_n), 64'd1);
    tick();

    // Backpressure on beat 1
    accept(1'b0, 16'd1, 5'd16);
    tick();
    chk_beat("t6b0", D0, 1, 1, 0, 1, 1'b0, 3'd1, 3'd7, 1);
    tick(); tick();
    sld_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk_beat("t6hold", D1, 1, 0, 1, 1, 1'b1, 3'd1, 3'd7, 1);
      chk("t6hold.done", 64'(done_o), 64'd0);
      tick();
    end
    sld_ready_i = 1'b1;
    chk_beat("t6b1", D1, 1, 0, 1, 1, 1'b1, 3'd1, 3'd7, 1);
    tick();
    chk("t6.done", 64'(done_o), 64'd1);
    chk("t6.rd_n", 64'(rd_n), 64'd2);
    tick();

    // Reset while a beat is waiting in ISSUE
    accept(1'b0, 16'd3, 5'd16);
    sld_ready_i = 1'b0;
    tick();
    chk("t7.issue", 64'(sld_valid_o), 64'd1);
    #1;
    async_rst_i = 1'b1;
    #1;
    chk("t7.valid", 64'(sld_valid_o), 64'd0);
    chk("t7.ready", 64'(cmd_ready_o), 64'd1);
    chk("t7.first", 64'(sld_first_o), 64'd0);
    chk("t7.op", sld_op_o, 64'd0);
    chk("t7.shift", 64'(sld_shift_o), 64'd0);
    chk("t7.done", 64'(done_o), 64'd0);
    tick();
    chk("t7.done_hold", 64'(done_o), 64'd0);
    async_rst_i = 1'b0;
    sld_ready_i = 1'b1;
    tick();
    chk("t7.done_after", 64'(done_o), 64'd0);

    accept(1'b0, 16'd0, 5'd5);
    tick();
    chk_beat("t8b0", D0, 1, 1, 1, 1, 1'b0, 3'd0, 3'd4, 1);
    tick();
    chk("t8.done", 64'(done_o), 64'd1);
    tick();
    chk("t8.idle", 64'(cmd_ready_o), 64'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
